// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the synchronous event FIFO family.
package fifo_pkg;

  typedef enum logic {
    MODE_STD  = 1'b0,
    MODE_FWFT = 1'b1
  } fifo_mode_e;

  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  // One extra bit so a completely full FIFO is distinguishable from empty.
  function automatic int unsigned fifo_count_width(input int unsigned addr_width);
    return addr_width + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_bram_sdp.sv
// Simple dual-port RAM, synchronous read with read enable, no reset on the array.
module fifo_bram_sdp
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fifo_fwft_sync.sv
// Single-clock FIFO with standard or first-word-fall-through read, fill level,
// almost-full/almost-empty thresholds, sticky overflow/underflow and flush.
module fifo_fwft_sync
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned FWFT       = 0,
  parameter int unsigned AF_THRESH  = fifo_depth(ADDR_WIDTH) - 32'd2,
  parameter int unsigned AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  write_en,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_en,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);
  localparam int unsigned CW    = fifo_count_width(ADDR_WIDTH);
  localparam fifo_mode_e  MODE  = (FWFT != 0) ? MODE_FWFT : MODE_STD;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]         count_r;
  logic                  full_i;
  logic                  empty_i;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  ram_we;
  logic                  ram_rd;
  logic [DATA_WIDTH-1:0] ram_q;

  assign full_i = (count_r == DEPTH_C);
  assign wr_acc = write_en & ~full_i;
  assign rd_acc = read_en & ~empty_i;
  assign ram_we = wr_acc & ~rst & ~flush;

  fifo_bram_sdp #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr),
    .wdata (write_data),
    .re    (ram_rd),
    .raddr (rd_ptr),
    .rdata (ram_q)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_r   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (ram_rd) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      if (wr_acc && !rd_acc)      count_r <= count_r + CW'(1);
      else if (!wr_acc && rd_acc) count_r <= count_r - CW'(1);
      if (write_en && full_i) overflow  <= 1'b1;
      if (read_en && empty_i) underflow <= 1'b1;
    end
  end

  if (MODE == MODE_STD) begin : g_std
    logic valid_r;
    logic seen_r;

    assign empty_i = (count_r == '0);
    assign ram_rd  = rd_acc & ~rst & ~flush;

    // The RAM output register cannot be reset, so it is masked until the
    // first read after reset; it then holds its value between reads.
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_r <= 1'b0;
        seen_r  <= 1'b0;
      end else if (flush) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= rd_acc;
        if (rd_acc) seen_r <= 1'b1;
      end
    end

    assign read_valid = valid_r;
    assign read_data  = seen_r ? ram_q : '0;
  end else begin : g_fwft
    logic                  out_valid;
    logic                  q_valid;
    logic                  out_load;
    logic                  q_free;
    logic [DATA_WIDTH-1:0] out_data;
    logic [CW-1:0]         mem_cnt;

    // Two-stage prefetch: the RAM output latch holds the next word so a pop
    // can refill the output register on the same edge.
    assign mem_cnt  = count_r - CW'(out_valid) - CW'(q_valid);
    assign out_load = q_valid & (~out_valid | rd_acc);
    assign q_free   = ~q_valid | out_load;
    assign ram_rd   = q_free & (mem_cnt != '0) & ~rst & ~flush;
    assign empty_i  = ~out_valid;

    always_ff @(posedge clk) begin
      if (rst) begin
        out_valid <= 1'b0;
        q_valid   <= 1'b0;
        out_data  <= '0;
      end else if (flush) begin
        out_valid <= 1'b0;
        q_valid   <= 1'b0;
      end else begin
        if (out_load) begin
          out_valid <= 1'b1;
          out_data  <= ram_q;
        end else if (rd_acc) begin
          out_valid <= 1'b0;
        end
        if (ram_rd)        q_valid <= 1'b1;
        else if (out_load) q_valid <= 1'b0;
      end
    end

    assign read_valid = out_valid;
    assign read_data  = out_data;
  end

  assign full         = full_i;
  assign empty        = empty_i;
  assign count        = count_r;
  assign almost_full  = (count_r >= AF_C);
  assign almost_empty = (count_r <= AE_C);

endmodule
